// File: rtl/des_cbc_dec.sv
// des_cbc_dec: CBC-mode decryption chaining around a pipelined DES core.
// Ciphertext goes to the core (always set to decrypt). The ciphertext
// preceding each block, or the IV for the first one, waits in an alignment
// FIFO until the core returns that block. The XORed plaintext is then queued
// in an output FIFO. A credit check bounds the number of blocks inside the
// unit to FIFO_DEPTH, because the core itself cannot be stalled.
// Optional feature: define DES_CBC_ERR_EN to enable the sticky `err` flag.
// With the macro defined, `err` reports unmatched core results and IV loads
// made while blocks are in flight. Without it, `err` is tied low.

module des_cbc_dec #(
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        core_valid_in,
    output logic [63:0] core_data_in,
    output logic        core_encrypt_decrypt,
    input  logic        core_valid_out,
    input  logic [63:0] core_data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic [63:0]   chain_q, chain_d;
    logic          core_valid_q, core_valid_d;
    logic [63:0]   core_data_q, core_data_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [AW-1:0] align_wr_q, align_wr_d;
    logic [AW-1:0] align_rd_q, align_rd_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic [AW-1:0] out_wr_q, out_wr_d;
    logic [AW-1:0] out_rd_q, out_rd_d;

    logic [63:0]   align_mem_q [FIFO_DEPTH];
    logic [63:0]   out_mem_q   [FIFO_DEPTH];

    logic          accept;
    logic          core_ret;
    logic          out_pop;
    logic [CW:0]   credit_used;
    logic [63:0]   plain;

    // Blocks in the core plus plaintext waiting in the output FIFO can never
    // exceed FIFO_DEPTH, so neither FIFO can overflow whatever the core latency.
    assign credit_used = {1'b0, inflight_q} + {1'b0, out_count_q};
    assign in_ready    = !iv_load && (credit_used < CREDIT_LIMIT);
    assign accept      = in_valid && in_ready;

    // A core result with nothing queued for alignment has no chain value
    // to pair with, so it is ignored.
    assign core_ret    = core_valid_out && (inflight_q != '0);
    assign plain       = core_data_out ^ align_mem_q[align_rd_q];

    assign out_valid   = (out_count_q != '0);
    assign out_pop     = out_valid && out_ready;
    assign out_data    = out_valid ? out_mem_q[out_rd_q] : 64'd0;

    assign core_valid_in        = core_valid_q;
    assign core_data_in         = core_data_q;
    assign core_encrypt_decrypt = 1'b1;

    // Next-state for the chain register, core handoff, pointers and counters.
    always_comb begin
        chain_d      = chain_q;
        core_valid_d = accept;
        core_data_d  = core_data_q;
        inflight_d   = inflight_q;
        align_wr_d   = align_wr_q;
        align_rd_d   = align_rd_q;
        out_count_d  = out_count_q;
        out_wr_d     = out_wr_q;
        out_rd_d     = out_rd_q;

        if (iv_load) begin
            chain_d = iv;
        end else if (accept) begin
            chain_d = in_data;
        end

        if (accept) begin
            core_data_d = in_data;
            align_wr_d  = align_wr_q + AW'(1);
        end

        if (core_ret) begin
            align_rd_d = align_rd_q + AW'(1);
            out_wr_d   = out_wr_q + AW'(1);
        end

        if (out_pop) begin
            out_rd_d = out_rd_q + AW'(1);
        end

        case ({accept, core_ret})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        case ({core_ret, out_pop})
            2'b10:   out_count_d = out_count_q + CW'(1);
            2'b01:   out_count_d = out_count_q - CW'(1);
            default: out_count_d = out_count_q;
        endcase
    end

    // Control and datapath registers. Reset discards all queued and in-flight blocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_q      <= 64'd0;
            core_valid_q <= 1'b0;
            core_data_q  <= 64'd0;
            inflight_q   <= '0;
            align_wr_q   <= '0;
            align_rd_q   <= '0;
            out_count_q  <= '0;
            out_wr_q     <= '0;
            out_rd_q     <= '0;
        end else begin
            chain_q      <= chain_d;
            core_valid_q <= core_valid_d;
            core_data_q  <= core_data_d;
            inflight_q   <= inflight_d;
            align_wr_q   <= align_wr_d;
            align_rd_q   <= align_rd_d;
            out_count_q  <= out_count_d;
            out_wr_q     <= out_wr_d;
            out_rd_q     <= out_rd_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            align_mem_q[align_wr_q] <= chain_q;
        end
        if (core_ret) begin
            out_mem_q[out_wr_q] <= plain;
        end
    end

`ifdef DES_CBC_ERR_EN
    logic err_q, err_d;

    // Sticky protocol error: unmatched core result, or IV reload while blocks are in flight.
    always_comb begin
        err_d = err_q;
        if (core_valid_out && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (iv_load && (inflight_q != '0)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
